// File: rtl/coram_stream_host_peer_pkg.sv
// coram_stream_host_peer_pkg: shared FSM encoding and protocol constants for the stream-sum host peer
package coram_stream_host_peer_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GO    = 3'd1,
      S_FILL  = 3'd2,
      S_WSUM  = 3'd3,
      S_CHK   = 3'd4,
      S_DRAIN = 3'd5,
      S_ACK   = 3'd6,
      S_FIN   = 3'd7
   } state_t;
   localparam int unsigned ACK_TOKEN = 0;
   localparam int unsigned RD_LAT = 1;
endpackage

// File: rtl/coram_stream_host_peer_checker.sv
// coram_stream_checker: delayed-dequeue data check, sum check and saturating error count
module coram_stream_checker
   import coram_stream_host_peer_pkg::*;
#(
   parameter int unsigned W_D = 32,
   parameter int unsigned SIZE = 128
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           clr_err,
   input  logic           clr_idx,
   input  logic           os_deq,
   input  logic [W_D-1:0] os_q,
   input  logic           sum_vld,
   input  logic [W_D-1:0] sum_q,
   input  logic [W_D-1:0] exp_sum,
   output logic           err,
   output logic [31:0]    err_cnt,
   output logic           last
);
   logic [RD_LAT-1:0] dq;
   logic d_os_deq, bad;
   logic [31:0] chk_cnt;
   assign d_os_deq = dq[RD_LAT-1];
   // word and sum checks never land in the same cycle, so one increment covers both
   assign bad = (d_os_deq && os_q != W_D'(chk_cnt)) || (sum_vld && sum_q != exp_sum);
   assign last = d_os_deq && chk_cnt == SIZE - 1;
   always_ff @(posedge CLK) begin
      if (RST) begin
         dq <= '0;
         chk_cnt <= '0;
         err <= 1'b0;
         err_cnt <= '0;
      end else begin
         dq <= RD_LAT'({dq, os_deq});
         chk_cnt <= clr_idx ? '0 : chk_cnt + 32'(d_os_deq);
         err <= !clr_err && (err || bad);
         err_cnt <= clr_err ? '0 : (bad && err_cnt != '1) ? err_cnt + 32'd1 : err_cnt;
      end
   end
endmodule

// File: rtl/coram_stream_host_peer.sv
// coram_stream_host_peer: hardware stand-in for the stream-sum control thread
module coram_stream_host_peer
   import coram_stream_host_peer_pkg::*;
#(
   parameter int unsigned    W_D = 32,
   parameter int unsigned    SIZE = 128,
   parameter logic [W_D-1:0] BASE = '0,
   parameter int unsigned    ITER = 1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           start,
   output logic [W_D-1:0] is_d,
   output logic           is_enq,
   input  logic           is_full,
   input  logic [W_D-1:0] os_q,
   output logic           os_deq,
   input  logic           os_empty,
   output logic [W_D-1:0] ch_d,
   output logic           ch_enq,
   input  logic           ch_full,
   input  logic [W_D-1:0] ch_q,
   output logic           ch_deq,
   input  logic           ch_empty,
   output logic           busy,
   output logic           done,
   output logic [W_D-1:0] sum_rcv,
   output logic           err,
   output logic [31:0]    err_cnt
);
   state_t state, nxt;
   logic [31:0] wr_cnt, rd_cnt, iter_cnt;
   logic [W_D-1:0] exp_sum;
   logic ch_pend, last;
   assign is_enq = state == S_FILL && !is_full && wr_cnt < SIZE;
   assign is_d = state == S_FILL ? BASE + W_D'(wr_cnt) : '0;
   assign os_deq = state == S_DRAIN && !os_empty && rd_cnt < SIZE;
   assign ch_deq = state == S_WSUM && !ch_empty && !ch_pend;
   assign ch_enq = (state == S_GO || state == S_ACK) && !ch_full;
   assign ch_d = state == S_GO ? W_D'(SIZE) : W_D'(ACK_TOKEN);
   assign busy = state != S_IDLE;
   assign done = state == S_FIN;
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = start ? S_GO : S_IDLE;
         S_GO:    nxt = ch_full ? S_GO : S_FILL;
         S_FILL:  nxt = is_enq && wr_cnt == SIZE - 1 ? S_WSUM : S_FILL;
         S_WSUM:  nxt = ch_deq ? S_CHK : S_WSUM;
         S_CHK:   nxt = S_DRAIN;
         S_DRAIN: nxt = last ? S_ACK : S_DRAIN;
         S_ACK:   nxt = ch_full ? S_ACK : iter_cnt + 32'd1 < ITER ? S_GO : S_FIN;
         S_FIN:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         wr_cnt <= '0;
         rd_cnt <= '0;
         iter_cnt <= '0;
         exp_sum <= '0;
         sum_rcv <= '0;
         ch_pend <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) iter_cnt <= '0;
         if (state == S_ACK && !ch_full) iter_cnt <= iter_cnt + 32'd1;
         if (state == S_GO) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            exp_sum <= '0;
         end
         // expected sum is built from the words actually sent, avoiding a multiplier
         if (is_enq) begin
            wr_cnt <= wr_cnt + 32'd1;
            exp_sum <= exp_sum + is_d;
         end
         if (os_deq) rd_cnt <= rd_cnt + 32'd1;
         if (ch_deq) ch_pend <= 1'b1;
         if (state == S_CHK) begin
            ch_pend <= 1'b0;
            sum_rcv <= ch_q;
         end
      end
   end
   coram_stream_checker #(.W_D(W_D), .SIZE(SIZE)) u_chk (
      .CLK     (CLK),
      .RST     (RST),
      .clr_err (state == S_IDLE && start),
      .clr_idx (state == S_GO),
      .os_deq  (os_deq),
      .os_q    (os_q),
      .sum_vld (state == S_CHK),
      .sum_q   (ch_q),
      .exp_sum (exp_sum),
      .err     (err),
      .err_cnt (err_cnt),
      .last    (last)
   );
endmodule

// File: tb/tb_coram_stream_host_peer.sv
// tb_coram_stream_host_peer: directed checks of the host peer against a behavioural stream-sum user logic
module tb_coram_stream_host_peer;
   import coram_stream_host_peer_pkg::*;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start_r [2];
   logic tog [2];
   int hold [2];
   logic bad_sum [2];
   logic bad_word [2];
   wire [31:0] ndone_w [2];
   int ncmp = 0;
   int nbad = 0;
   int e0, q0, d0, t0, n;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 2; g++) begin : u
      logic is_full = 1'b0;
      logic os_empty = 1'b1;
      logic ch_empty = 1'b1;
      logic ch_full = 1'b0;
      logic [31:0] os_q = '0;
      logic [31:0] ch_q = '0;
      logic is_enq, os_deq, ch_enq, ch_deq, busy, done, err;
      logic [31:0] is_d, ch_d, sum_rcv, err_cnt;
      logic s_e, s_d, s_ce, s_cd;
      logic [31:0] s_dv, s_cv, acc, sum_v;
      logic sum_av = 1'b0;
      int n_enq = 0, n_deq = 0, n_done = 0, n_viol = 0, n_in = 0, blk = 0;
      logic [31:0] toks [$];
      logic [31:0] ofifo [$];
      coram_stream_host_peer #(.W_D(32), .SIZE(128), .BASE(g ? 32'd5 : 32'd0), .ITER(g ? 3 : 1)) dut (
         .CLK(CLK), .RST(RST), .start(start_r[g]),
         .is_d(is_d), .is_enq(is_enq), .is_full(is_full),
         .os_q(os_q), .os_deq(os_deq), .os_empty(os_empty),
         .ch_d(ch_d), .ch_enq(ch_enq), .ch_full(ch_full),
         .ch_q(ch_q), .ch_deq(ch_deq), .ch_empty(ch_empty),
         .busy(busy), .done(done), .sum_rcv(sum_rcv), .err(err), .err_cnt(err_cnt)
      );
      assign ndone_w[g] = 32'(n_done);
      always @(posedge CLK) begin
         s_e = is_enq; s_d = os_deq; s_ce = ch_enq; s_cd = ch_deq; s_dv = is_d; s_cv = ch_d;
         if ((s_e && is_full) || (s_d && os_empty) || (s_ce && ch_full) || (s_cd && ch_empty)) n_viol++;
         if (done && !RST) n_done++;
         #1;
         if (RST) begin
            n_in = 0; acc = '0; sum_av = 1'b0; ofifo.delete(); blk = 0; is_full = 1'b0;
         end else begin
            if (blk > 0) blk--;
            if (s_ce) begin
               toks.push_back(s_cv);
               if (s_cv != 0) begin n_in = 0; acc = '0; end
            end
            if (s_e) begin
               acc = acc + s_dv; n_in++; n_enq++;
               if (n_in == 128) begin
                  sum_av = 1'b1;
                  sum_v = bad_sum[g] ? acc - 32'd1 : acc;
                  blk = hold[g];
                  for (int i = 0; i < 128; i++) ofifo.push_back((bad_word[g] && i == 7) ? 32'hFFFF : 32'(i));
               end
            end
            if (s_cd) begin ch_q = sum_v; sum_av = 1'b0; end
            if (s_d && ofifo.size() > 0) begin os_q = ofifo.pop_front(); n_deq++; end
            is_full = tog[g] ? !is_full : 1'b0;
         end
         ch_empty = !sum_av;
         os_empty = ofifo.size() == 0 || blk > 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int k, input int budget);
      int d, c;
      d = ndone_w[k];
      start_r[k] = 1'b1; @(posedge CLK); #2; start_r[k] = 1'b0;
      c = 0;
      while (ndone_w[k] == d && c < budget) begin @(posedge CLK); #2; c++; end
      chk("run_timeout", 32'(c < budget), 32'd1);
      repeat (5) @(posedge CLK);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_r[i] = 1'b0; tog[i] = 1'b0; hold[i] = 0; bad_sum[i] = 1'b0; bad_word[i] = 1'b0;
      end
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
      chk("rst_busy", u[0].busy, 0);
      chk("rst_done", u[0].done, 0);
      chk("rst_is_enq", u[0].is_enq, 0);
      chk("rst_ch_enq", u[0].ch_enq, 0);
      chk("rst_is_d", u[0].is_d, 0);
      chk("rst_ch_d", u[0].ch_d, 0);
      chk("rst_err", u[0].err, 0);
      chk("rst_err_cnt", u[0].err_cnt, 0);
      chk("rst_sum", u[0].sum_rcv, 0);

      e0 = u[0].n_enq; q0 = u[0].n_deq; d0 = u[0].n_done;
      run(0, 2000);
      chk("a_enq", u[0].n_enq - e0, 128);
      chk("a_deq", u[0].n_deq - q0, 128);
      chk("a_sum", u[0].sum_rcv, 8128);
      chk("a_err", u[0].err, 0);
      chk("a_err_cnt", u[0].err_cnt, 0);
      chk("a_done", u[0].n_done - d0, 1);
      chk("a_busy", u[0].busy, 0);
      chk("a_tok_go", u[0].toks[0], 128);
      chk("a_tok_ack", u[0].toks[1], 0);

      tog[0] = 1'b1; hold[0] = 50;
      e0 = u[0].n_enq; q0 = u[0].n_deq;
      run(0, 2000);
      tog[0] = 1'b0; hold[0] = 0;
      chk("b_enq", u[0].n_enq - e0, 128);
      chk("b_deq", u[0].n_deq - q0, 128);
      chk("b_sum", u[0].sum_rcv, 8128);
      chk("b_err", u[0].err, 0);
      chk("b_viol", u[0].n_viol, 0);

      bad_sum[0] = 1'b1; bad_word[0] = 1'b1;
      d0 = u[0].n_done;
      run(0, 2000);
      bad_sum[0] = 1'b0; bad_word[0] = 1'b0;
      chk("c_err", u[0].err, 1);
      chk("c_err_cnt", u[0].err_cnt, 2);
      chk("c_sum", u[0].sum_rcv, 8127);
      chk("c_done", u[0].n_done - d0, 1);

      run(0, 2000);
      chk("d_err_cleared", u[0].err, 0);
      chk("d_err_cnt_cleared", u[0].err_cnt, 0);

      e0 = u[0].n_enq;
      start_r[0] = 1'b1; @(posedge CLK); #2; start_r[0] = 1'b0;
      n = 0;
      while (u[0].n_enq - e0 < 40 && n < 500) begin @(posedge CLK); #2; n++; end
      chk("e_fill_timeout", 32'(n < 500), 1);
      RST = 1'b1;
      @(posedge CLK); #2;
      chk("e_is_enq", u[0].is_enq, 0);
      chk("e_os_deq", u[0].os_deq, 0);
      chk("e_ch_enq", u[0].ch_enq, 0);
      chk("e_ch_deq", u[0].ch_deq, 0);
      chk("e_busy", u[0].busy, 0);
      chk("e_state", 32'(u[0].dut.state), 32'(S_IDLE));
      RST = 1'b0;
      @(posedge CLK); #2;
      e0 = u[0].n_enq; q0 = u[0].n_deq;
      run(0, 2000);
      chk("e_enq", u[0].n_enq - e0, 128);
      chk("e_deq", u[0].n_deq - q0, 128);
      chk("e_sum", u[0].sum_rcv, 8128);
      chk("e_err", u[0].err, 0);

      t0 = u[1].toks.size(); e0 = u[1].n_enq; q0 = u[1].n_deq; d0 = u[1].n_done;
      start_r[1] = 1'b1; @(posedge CLK); #2; start_r[1] = 1'b0;
      repeat (50) @(posedge CLK);
      #2;
      start_r[1] = 1'b1; @(posedge CLK); #2; start_r[1] = 1'b0;
      n = 0;
      while (u[1].n_done == d0 && n < 3000) begin @(posedge CLK); #2; n++; end
      chk("f_timeout", 32'(n < 3000), 1);
      repeat (300) @(posedge CLK);
      #2;
      chk("f_done", u[1].n_done - d0, 1);
      chk("f_ntok", u[1].toks.size() - t0, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("f_tok%0d", i), u[1].toks[t0 + i], (i % 2) ? 32'd0 : 32'd128);
      chk("f_sum", u[1].sum_rcv, 8768);
      chk("f_err", u[1].err, 0);
      chk("f_err_cnt", u[1].err_cnt, 0);
      chk("f_enq", u[1].n_enq - e0, 384);
      chk("f_deq", u[1].n_deq - q0, 384);
      chk("f_busy", u[1].busy, 0);
      chk("f_viol", u[1].n_viol, 0);
      chk("all_viol", u[0].n_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule

// File: doc/coram_stream_host_peer.md
Name: coram_stream_host_peer

Overview:
- Hardware peer that drives the far end of the stream-sum protocol, emulating the control thread.
- Produces SIZE words into the input-stream FIFO (enqueue side) and exchanges go/sum/ack tokens over the bidirectional channel FIFO.
- Drains and checks SIZE words from the output-stream FIFO (dequeue side).
- Used in self-checking simulation and in on-board bring-up of stream user logic without a soft-core control thread.

Parameters:
- W_D, 32, data width of all stream and channel words
- SIZE, 128, words per transfer in each direction (1..2^31)
- BASE, 0, value of input word 0; input word i = BASE+i (mod 2^W_D)
- ITER, 1, transfers per start pulse (>=1)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; accepted only in IDLE
- is_d  out  W_D  input-stream enqueue data
- is_enq  out  1  input-stream enqueue strobe
- is_full  in  1  input-stream FIFO full
- os_q  in  W_D  output-stream dequeue data, valid the cycle after os_deq
- os_deq  out  1  output-stream dequeue strobe
- os_empty  in  1  output-stream FIFO empty
- ch_d  out  W_D  channel write data (to user logic)
- ch_enq  out  1  channel write strobe
- ch_full  in  1  channel full
- ch_q  in  W_D  channel read data, valid the cycle after ch_deq
- ch_deq  out  1  channel read strobe
- ch_empty  in  1  channel empty
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the final iteration completes
- sum_rcv  out  W_D  last sum received from the user logic
- err  out  1  sticky: sum mismatch or output data mismatch
- err_cnt  out  32  saturating count of mismatched words and sums

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: all strobes 0, is_d/ch_d 0, busy 0, done 0, sum_rcv 0, err 0, err_cnt 0, state IDLE, counters 0. Reset mid-operation aborts immediately; no partial token is sent.
- States: IDLE, GO, FILL, WSUM, CHK, DRAIN, ACK, FIN.
- IDLE: on start, clear err, err_cnt and iteration count, then go to GO.
- GO: when !ch_full, drive ch_enq=1 with ch_d=SIZE for one cycle, then go to FILL.
- FILL:
  - is_enq = (state==FILL) && !is_full && (wr_cnt<SIZE), combinational.
  - is_d = BASE+wr_cnt, combinational.
  - wr_cnt increments on each enq; after SIZE enqs, go to WSUM.
- WSUM:
  - When !ch_empty and no read is pending, pulse ch_deq; the next cycle go to CHK.
  - exp_sum = SIZE*BASE + SIZE*(SIZE-1)/2 (mod 2^W_D), accumulated in a register during FILL, not by multiplier.
- CHK: latch ch_q into sum_rcv. If it differs from exp_sum, set err and increment err_cnt. Go to DRAIN.
- DRAIN:
  - os_deq = (state==DRAIN) && !os_empty && (rd_cnt<SIZE).
  - d_os_deq is registered.
  - When d_os_deq, compare os_q to chk_cnt (expected value = word index 0..SIZE-1), then increment chk_cnt.
  - After SIZE compares, i.e. when the last delayed compare finishes, go to ACK.
- ACK: when !ch_full, pulse ch_enq with ch_d=0. Go to GO if more iterations remain, else FIN.
- FIN: done=1 for one cycle, then IDLE.
- err_cnt saturates at 2^32-1.
- start outside IDLE is ignored.
- Strobes never assert while the corresponding full/empty input is high in the same cycle.
- Back-to-back strobes are allowed every cycle.

Decomposition:
- Shared package:
  - state encoding constants (3-bit)
  - ACK token value 0
  - the read-latency constant (1)
- Natural sub-module: coram_stream_checker, which holds the delayed-deq register, expected-index counter, comparator and saturating err_cnt. The top keeps the FSM and the producer.

Test Plan:
- Reference user logic, SIZE=128, BASE=0, ITER=1, start pulse -> 128 is_enq, sum_rcv=8128, err=0, done pulse once, busy low afterward.
- Same setup, BASE=5 -> sum_rcv = 8128+640 = 8768, err=0.
- is_full toggled every other cycle and os_empty held high 50 cycles -> no strobe while blocked, still 128 words each way, err=0.
- Model returns sum 8127 and corrupts output word 7 to 0xFFFF → err=1, err_cnt=2, done still pulses.
- ITER=3 -> three GO and three ACK tokens observed on ch_d (128,0,128,0,128,0), done exactly once.
- RST asserted mid-FILL after 40 words → next cycle: all strobes 0, busy 0, state IDLE; a new start completes a clean transfer.
